// File: rtl/systolic_controller.sv
// rtl/systolic_controller.sv - job sequencer driving the systolic-array buffer and weight-write enables
//
// Purpose: turns a single start/done host handshake into the fixed per-job schedule
//   LOAD_W -> PUSH_W -> LOAD_A -> COMPUTE -> DRAIN -> DONE, or LOAD_A onward when reuse_weight=1.
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   start, reuse_weight      job request and weight-reuse flag, both sampled only in IDLE
//   busy, done               job in progress; one-cycle completion pulse
//   weight_req, act_req      host must present in_weight / in_act this cycle
//   res_valid                out_res of the array top is valid this cycle
//   *_en                     buffer and weight-write enables to the array top
module systolic_controller #(
  parameter int ARRAYWIDTH = 4,
  parameter int OUT_LAT    = 2*ARRAYWIDTH-1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic reuse_weight,
  output logic busy,
  output logic done,
  output logic weight_req,
  output logic act_req,
  output logic res_valid,
  output logic weight_buffer_load_en,
  output logic weight_buffer_out_en,
  output logic write_weight_en,
  output logic input_buffer_load_en,
  output logic input_buffer_out_en,
  output logic output_buffer_load_en,
  output logic output_buffer_out_en
);

  localparam int CW = $clog2(OUT_LAT + ARRAYWIDTH) + 1;
  localparam logic [CW-1:0] LAST_N   = CW'(ARRAYWIDTH - 1);
  localparam logic [CW-1:0] LAST_C   = CW'(OUT_LAT + ARRAYWIDTH - 1);
  localparam logic [CW-1:0] OB_FIRST = CW'(OUT_LAT);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, PUSH_W, LOAD_A, COMPUTE, DRAIN, DONE
  } state_t;

  state_t          state, nxt_state;
  logic [CW-1:0]   cnt, nxt_cnt;
  logic            last;

  // Last cycle of the current phase.
  always_comb begin
    last = 1'b0;
    case (state)
      LOAD_W, PUSH_W, LOAD_A, DRAIN: last = (cnt == LAST_N);
      COMPUTE:                       last = (cnt == LAST_C);
      DONE:                          last = 1'b1;
      default:                       last = 1'b0;
    endcase
  end

  // reuse_weight only matters on the accepting edge: the chosen first state is its latched form.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 1'b1;
    if (state == IDLE) begin
      nxt_cnt = '0;
      if (start) nxt_state = reuse_weight ? LOAD_A : LOAD_W;
    end else if (last) begin
      nxt_cnt = '0;
      case (state)
        LOAD_W:  nxt_state = PUSH_W;
        PUSH_W:  nxt_state = LOAD_A;
        LOAD_A:  nxt_state = COMPUTE;
        COMPUTE: nxt_state = DRAIN;
        DRAIN:   nxt_state = DONE;
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state/count so they are registered yet line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      weight_req            <= 1'b0;
      act_req               <= 1'b0;
      res_valid             <= 1'b0;
      weight_buffer_load_en <= 1'b0;
      weight_buffer_out_en  <= 1'b0;
      write_weight_en       <= 1'b0;
      input_buffer_load_en  <= 1'b0;
      input_buffer_out_en   <= 1'b0;
      output_buffer_load_en <= 1'b0;
      output_buffer_out_en  <= 1'b0;
    end else begin
      state                 <= nxt_state;
      cnt                   <= nxt_cnt;
      busy                  <= (nxt_state != IDLE);
      done                  <= (nxt_state == DONE);
      weight_req            <= (nxt_state == LOAD_W);
      weight_buffer_load_en <= (nxt_state == LOAD_W);
      weight_buffer_out_en  <= (nxt_state == PUSH_W);
      write_weight_en       <= (nxt_state == PUSH_W);
      act_req               <= (nxt_state == LOAD_A);
      input_buffer_load_en  <= (nxt_state == LOAD_A);
      input_buffer_out_en   <= (nxt_state == COMPUTE);
      // Column sums reach the output buffer only after the array pipeline latency.
      output_buffer_load_en <= (nxt_state == COMPUTE) && (nxt_cnt >= OB_FIRST);
      output_buffer_out_en  <= (nxt_state == DRAIN);
      // The output buffer registers its read data, so results trail the read enable by one cycle.
      res_valid             <= output_buffer_out_en;
    end
  end

endmodule

// File: tb/tb_systolic_controller.sv
// tb/tb_systolic_controller.sv - scoreboard bench for systolic_controller
module tb_systolic_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic reuse_weight = 1'b0;
  logic busy, done, weight_req, act_req, res_valid;
  logic weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic input_buffer_load_en, input_buffer_out_en, output_buffer_load_en, output_buffer_out_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];

  systolic_controller #(.ARRAYWIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .reuse_weight(reuse_weight),
    .busy(busy), .done(done), .weight_req(weight_req), .act_req(act_req), .res_valid(res_valid),
    .weight_buffer_load_en(weight_buffer_load_en), .weight_buffer_out_en(weight_buffer_out_en),
    .write_weight_en(write_weight_en), .input_buffer_load_en(input_buffer_load_en),
    .input_buffer_out_en(input_buffer_out_en), .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en(output_buffer_out_en)
  );

  always #5 clk = ~clk;

  // {busy,done,weight_req,act_req,res_valid,wbl,wbo,www,ibl,ibo,obl,obo}
  function automatic logic [11:0] outs();
    return {busy, done, weight_req, act_req, res_valid,
            weight_buffer_load_en, weight_buffer_out_en, write_weight_en,
            input_buffer_load_en, input_buffer_out_en, output_buffer_load_en, output_buffer_out_en};
  endfunction

  function automatic bit in_r(int t, int lo, int hi);
    return (t >= lo) && (t <= hi);
  endfunction

  // Hand-written schedule tables for N=4, OUT_LAT=7; t is relative to the start-accept cycle.
  function automatic logic [11:0] exp_full(int t);
    logic w1, w2, a1;
    w1 = in_r(t, 1, 4); w2 = in_r(t, 5, 8); a1 = in_r(t, 9, 12);
    return {in_r(t, 1, 28), t == 28, w1, a1, in_r(t, 25, 28),
            w1, w2, w2, a1, in_r(t, 13, 23), in_r(t, 20, 23), in_r(t, 24, 27)};
  endfunction

  function automatic logic [11:0] exp_reuse(int t);
    logic a1;
    a1 = in_r(t, 1, 4);
    return {in_r(t, 1, 20), t == 20, 1'b0, a1, in_r(t, 17, 20),
            3'b000, a1, in_r(t, 5, 15), in_r(t, 12, 15), in_r(t, 16, 19)};
  endfunction

  // Monitor: one expected vector is consumed per cycle while the scoreboard holds any.
  always @(negedge clk) begin
    logic [11:0] e;
    cyc <= cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks = n_checks + 1;
      if (outs() !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL sched cyc%0d got %b exp %b", cyc, outs(), e);
      end
      // Weight and input buffer enables must never overlap.
      n_checks = n_checks + 1;
      if ((weight_buffer_load_en | weight_buffer_out_en) & (input_buffer_load_en | input_buffer_out_en)) begin
        n_fail = n_fail + 1;
        $display("FAIL overlap cyc%0d got %b exp no overlap", cyc, outs());
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_checks = n_checks + 1;
    if (got !== want) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_q();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic push_idle(int n);
    for (int i = 0; i < n; i++) exp_q.push_back(12'h000);
  endtask

  initial begin
    int d0;
    // Reset held: everything low.
    #12;
    check("reset_outs", 32'(outs()), 0);
    tick(); tick();
    rst = 1'b0;
    push_idle(3);
    drain_q();

    // Full job.
    tick();
    start = 1'b1;
    for (int t = 0; t <= 29; t++) exp_q.push_back(exp_full(t));
    tick();
    start = 1'b0;
    drain_q();

    // Reuse job.
    start = 1'b1; reuse_weight = 1'b1;
    for (int t = 0; t <= 21; t++) exp_q.push_back(exp_reuse(t));
    tick();
    start = 1'b0; reuse_weight = 1'b0;
    drain_q();

    // Starts at cycles 3 and 28 ignored; start at 29 launches the next job.
    d0 = done_cnt;
    start = 1'b1;
    for (int t = 0; t <= 28; t++) exp_q.push_back(exp_full(t));
    for (int t = 0; t <= 29; t++) exp_q.push_back(exp_full(t));
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; tick(); start = 1'b0;              // cycle 3
    for (int i = 4; i < 28; i++) tick();
    start = 1'b1; tick(); tick(); start = 1'b0;      // cycles 28 and 29
    drain_q();
    check("done_pulses_b2b", 32'(done_cnt - d0), 2);

    // Reset during COMPUTE: outputs drop within the same cycle, no done afterwards.
    start = 1'b1;
    for (int t = 0; t <= 14; t++) exp_q.push_back(exp_full(t));
    tick(); start = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    check("pre_reset_ibo", 32'(input_buffer_out_en), 1);
    #1 rst = 1'b1;
    #1 check("async_reset_outs", 32'(outs()), 0);
    d0 = done_cnt;
    push_idle(30);
    tick(); tick();
    rst = 1'b0;
    drain_q();
    check("no_done_after_abort", 32'(done_cnt - d0), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
